cpu_operand_fetch: RTL and testbench
====================================

# cpu_operand_fetch

Operand-fetch stage between decode and execute. It accepts decoded instructions over a valid/ready handshake and drives the read addresses of the synchronous 2-read/1-write register file. It returns operands to execute one cycle later, with write-back forwarding and a per-register RAW scoreboard. The register file reads old data on a same-cycle write; this block hides that behaviour and any multi-cycle producer latency from execute.

## Interface
- `p_half_regfile`, 0, 1 = 16 registers; scoreboard shrinks to 16 entries and address bit 4 is ignored.
- `i_clk` in 1: global clock.
- `i_rst` in 1: global reset; asynchronous, active-high.
- `i_flush` in 1: kill the held instruction and clear the scoreboard.
- `i_dec_valid` / `o_dec_ready` in/out 1: decode handshake.
- `i_dec_rs1`, `i_dec_rs2`, `i_dec_rd` in 5: source and destination register indices.
- `i_dec_use_rs1`, `i_dec_use_rs2`, `i_dec_rd_we` in 1: operand-use and destination-write flags.
- `i_dec_tag` in 32: opaque sideband, carried through unchanged.
- `o_rf_rd1_addr`, `o_rf_rd2_addr` out 5: register-file read addresses.
- `i_rf_rd1_data`, `i_rf_rd2_data` in 32: register-file read data, valid one cycle after the address.
- `i_wb_en` in 1, `i_wb_addr` in 5, `i_wb_data` in 32: write-back, the same signals driven to the register-file write port.
- `o_ex_valid` / `i_ex_ready` out/in 1: execute handshake.
- `o_ex_rs1_data`, `o_ex_rs2_data` out 32: forwarded operands.
- `o_ex_rd` out 5, `o_ex_rd_we` out 1, `o_ex_tag` out 32: carried fields.
- `o_stall_raw` out 1: the held instruction is blocked by the scoreboard.

## Operation
- **Holding register B.** B holds one instruction: valid bit, rs1/rs2, use flags, rd, rd_we, tag.
- **Decode handshake.**
  - `o_dec_ready = !b_valid | ex_fire`.
  - `dec_fire = i_dec_valid & o_dec_ready` loads B.
  - `ex_fire = o_ex_valid & i_ex_ready`.
- **Read addresses.**
  - Address mux: `o_rf_rdN_addr = dec_fire ? i_dec_rsN : b_rsN`.
  - B is therefore re-read every cycle, so register-file data always reflects writes up to two edges earlier.
- **Forwarding.** Each cycle a capture register records {hit, data} when `i_wb_en` is set, `i_wb_addr != 0`, and `i_wb_addr` equals the address being issued. Operand priority:
  - current-cycle write-back matching `b_rsN`, non-zero;
  - captured write-back from the previous cycle;
  - `i_rf_rdN_data`.
  - rs = 0 always yields 0.
- **Scoreboard.** One busy bit per register; x0 is never busy.
  - Set `busy[o_ex_rd]` on `ex_fire & o_ex_rd_we & o_ex_rd != 0`.
  - Clear on `i_wb_en & i_wb_addr != 0`.
  - Set and clear of the same register in the same cycle: set wins.
- **RAW stall.**
  - `raw_stall = b_valid & ((use_rs1 & busy[rs1] & !wb_hit1) | (use_rs2 & busy[rs2] & !wb_hit2))`.
  - A current-cycle write-back to a busy source releases the stall in that cycle.
  - `o_ex_valid = b_valid & !raw_stall`; `o_stall_raw = raw_stall`.
  - `o_ex_valid` never depends on `i_ex_ready`.
- **Flush.** `i_flush` clears `b_valid`, all busy bits, and the capture registers.
  - It also forces `o_dec_ready = 0` for that cycle; decode is not accepted.
  - Write-backs of killed ops are suppressed downstream.
- **Half register file.** With `p_half_regfile = 1`, all indices use bits [3:0].

## Timing
- **Reset values.** All outputs are 0: `o_ex_valid`, `o_stall_raw`, data, rd, tag, rf addresses. `o_dec_ready` is 1, B is empty, the scoreboard is clear, and the capture registers are invalid.
- **Latency and throughput.** Accept in cycle N gives `o_ex_valid` at N+1 at the earliest. Throughput is 1 instruction per cycle back-to-back.
- **Back-pressure.** When `i_ex_ready = 0`, B holds. Operands keep refreshing, and the tag, rd and valid outputs stay stable.
- **Write-back timing.**
  - Write-back in cycle N to a source issued in N: forwarded via the capture register in N+1.
  - Write-back in N+1: forwarded combinationally.
- **Producer to consumer.**
  - A producer handed off in cycle N marks rd busy from N+1.
  - A dependent in B stalls until the cycle its write-back arrives, then issues in that same cycle.
- **Reset mid-operation.** Asserting `i_rst` while B is held drops the instruction immediately, with no handshake.

## Configuration
- **`CPU_OPFETCH_SCOREBOARD_EN` defined:** scoreboard and RAW stall as above.
- **Undefined:**
  - No busy bits; `raw_stall` and `o_stall_raw` are tied to 0.
  - `o_ex_valid = b_valid`.
  - Forwarding is unchanged.
  - Used when every producer writes back before any consumer reaches B.

## Test plan
- **Back-to-back stream.** Decode x1..x5 as sources with `i_ex_ready = 1` -> `o_ex_valid` from cycle 1. The register-file data is passed through and the tags are in order.
- **Same-cycle write bypass.** Issue rs1 = x3 while `i_wb_en = 1`, `i_wb_addr = 3`, `i_wb_data = 0xDEADBEEF`, and the register file returns stale 0x0 -> `o_ex_rs1_data = 0xDEADBEEF` next cycle.
- **Load-use stall.** Hand off rd = x7 with `rd_we = 1`, then a consumer with rs2 = x7 -> `o_stall_raw = 1` for 3 cycles. Write-back of x7 = 0x12345678 in cycle 4 -> same-cycle `o_ex_valid = 1` with `o_ex_rs2_data = 0x12345678`.
- **Execute back-pressure.** Hold `i_ex_ready = 0` for 4 cycles while x9 is written with 0xA5A5A5A5 -> operand updates to 0xA5A5A5A5, tag stable, `o_dec_ready = 0` throughout.
- **x0 handling.** Write-back to x0 = 0xFFFFFFFF with a consumer reading rs1 = x0 -> operand 0, no stall, busy[0] never set.
- **Flush and reset.**
  - `i_flush` with B valid and busy[5] set -> `o_ex_valid = 0` next cycle and a consumer of x5 does not stall.
  - Async `i_rst` mid-stream -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/cpu_operand_fetch_if.sv
// cpu_operand_fetch_if: decode, register-file, write-back and execute signals of the operand-fetch stage.
interface cpu_operand_fetch_if;
  logic        i_flush;
  logic        i_dec_valid;
  logic        o_dec_ready;
  logic [4:0]  i_dec_rs1;
  logic [4:0]  i_dec_rs2;
  logic [4:0]  i_dec_rd;
  logic        i_dec_use_rs1;
  logic        i_dec_use_rs2;
  logic        i_dec_rd_we;
  logic [31:0] i_dec_tag;
  logic [4:0]  o_rf_rd1_addr;
  logic [4:0]  o_rf_rd2_addr;
  logic [31:0] i_rf_rd1_data;
  logic [31:0] i_rf_rd2_data;
  logic        i_wb_en;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_ex_valid;
  logic        i_ex_ready;
  logic [31:0] o_ex_rs1_data;
  logic [31:0] o_ex_rs2_data;
  logic [4:0]  o_ex_rd;
  logic        o_ex_rd_we;
  logic [31:0] o_ex_tag;
  logic        o_stall_raw;
  modport slave (
    input  i_flush, i_dec_valid, i_dec_rs1, i_dec_rs2, i_dec_rd, i_dec_use_rs1, i_dec_use_rs2,
           i_dec_rd_we, i_dec_tag, i_rf_rd1_data, i_rf_rd2_data, i_wb_en, i_wb_addr, i_wb_data,
           i_ex_ready,
    output o_dec_ready, o_rf_rd1_addr, o_rf_rd2_addr, o_ex_valid, o_ex_rs1_data, o_ex_rs2_data,
           o_ex_rd, o_ex_rd_we, o_ex_tag, o_stall_raw
  );
  modport master (
    output i_flush, i_dec_valid, i_dec_rs1, i_dec_rs2, i_dec_rd, i_dec_use_rs1, i_dec_use_rs2,
           i_dec_rd_we, i_dec_tag, i_rf_rd1_data, i_rf_rd2_data, i_wb_en, i_wb_addr, i_wb_data,
           i_ex_ready,
    input  o_dec_ready, o_rf_rd1_addr, o_rf_rd2_addr, o_ex_valid, o_ex_rs1_data, o_ex_rs2_data,
           o_ex_rd, o_ex_rd_we, o_ex_tag, o_stall_raw
  );
endinterface

// File: rtl/cpu_operand_fetch.sv
// cpu_operand_fetch: one-entry operand-fetch stage with write-back forwarding.
// Define CPU_OPFETCH_SCOREBOARD_EN to add the per-register RAW scoreboard and stall.
module cpu_operand_fetch #(
  parameter bit p_half_regfile = 1'b0
) (
  input logic          i_clk,
  input logic          i_rst,
  cpu_operand_fetch_if.slave bus
);
  localparam logic [4:0] MSK = p_half_regfile ? 5'h0f : 5'h1f;
  logic        b_valid_q, b_valid_d;
  logic [4:0]  b_rs1_q, b_rs2_q, b_rd_q;
  logic        b_use1_q, b_use2_q, b_rd_we_q;
  logic [31:0] b_tag_q;
  logic        cap1_hit_q, cap1_hit_d, cap2_hit_q, cap2_hit_d;
  logic [31:0] cap1_data_q, cap2_data_q;
  logic [4:0]  wb_addr;
  logic        wb_v, wb_hit1, wb_hit2, dec_fire, ex_fire, raw_stall;
  assign wb_addr = bus.i_wb_addr & MSK;
  assign wb_v    = bus.i_wb_en & (wb_addr != 5'd0);
  assign wb_hit1 = wb_v & (wb_addr == b_rs1_q);
  assign wb_hit2 = wb_v & (wb_addr == b_rs2_q);
  assign bus.o_dec_ready = (!b_valid_q | ex_fire) & !bus.i_flush;
  assign dec_fire        = bus.i_dec_valid & bus.o_dec_ready;
  assign bus.o_ex_valid  = b_valid_q & !raw_stall;
  assign ex_fire         = bus.o_ex_valid & bus.i_ex_ready;
  assign bus.o_stall_raw = raw_stall;
  // B is re-read whenever nothing new is accepted, so the RF data tracks late write-backs.
  assign bus.o_rf_rd1_addr = dec_fire ? (bus.i_dec_rs1 & MSK) : b_rs1_q;
  assign bus.o_rf_rd2_addr = dec_fire ? (bus.i_dec_rs2 & MSK) : b_rs2_q;
  assign bus.o_ex_rs1_data = (b_rs1_q == 5'd0) ? 32'd0 : wb_hit1 ? bus.i_wb_data :
                             cap1_hit_q ? cap1_data_q : bus.i_rf_rd1_data;
  assign bus.o_ex_rs2_data = (b_rs2_q == 5'd0) ? 32'd0 : wb_hit2 ? bus.i_wb_data :
                             cap2_hit_q ? cap2_data_q : bus.i_rf_rd2_data;
  assign bus.o_ex_rd    = b_rd_q;
  assign bus.o_ex_rd_we = b_rd_we_q;
  assign bus.o_ex_tag   = b_tag_q;
  assign b_valid_d  = bus.i_flush ? 1'b0 : dec_fire ? 1'b1 : ex_fire ? 1'b0 : b_valid_q;
  assign cap1_hit_d = !bus.i_flush & wb_v & (wb_addr == bus.o_rf_rd1_addr);
  assign cap2_hit_d = !bus.i_flush & wb_v & (wb_addr == bus.o_rf_rd2_addr);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      b_valid_q   <= 1'b0;
      b_rs1_q     <= '0;
      b_rs2_q     <= '0;
      b_rd_q      <= '0;
      b_use1_q    <= 1'b0;
      b_use2_q    <= 1'b0;
      b_rd_we_q   <= 1'b0;
      b_tag_q     <= '0;
      cap1_hit_q  <= 1'b0;
      cap2_hit_q  <= 1'b0;
      cap1_data_q <= '0;
      cap2_data_q <= '0;
    end else begin
      b_valid_q   <= b_valid_d;
      cap1_hit_q  <= cap1_hit_d;
      cap2_hit_q  <= cap2_hit_d;
      cap1_data_q <= bus.i_wb_data;
      cap2_data_q <= bus.i_wb_data;
      if (dec_fire) begin
        b_rs1_q   <= bus.i_dec_rs1 & MSK;
        b_rs2_q   <= bus.i_dec_rs2 & MSK;
        b_rd_q    <= bus.i_dec_rd & MSK;
        b_use1_q  <= bus.i_dec_use_rs1;
        b_use2_q  <= bus.i_dec_use_rs2;
        b_rd_we_q <= bus.i_dec_rd_we;
        b_tag_q   <= bus.i_dec_tag;
      end
    end
  end
`ifdef CPU_OPFETCH_SCOREBOARD_EN
  localparam int unsigned AW = p_half_regfile ? 4 : 5;
  localparam int unsigned NR = 1 << AW;
  logic [NR-1:0] busy_q, busy_d;
  // Set is applied after clear so a same-cycle handoff of the register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_v) busy_d[wb_addr[AW-1:0]] = 1'b0;
    if (ex_fire & b_rd_we_q & (b_rd_q != 5'd0)) busy_d[b_rd_q[AW-1:0]] = 1'b1;
    if (bus.i_flush) busy_d = '0;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) busy_q <= '0;
    else busy_q <= busy_d;
  assign raw_stall = b_valid_q & ((b_use1_q & busy_q[b_rs1_q[AW-1:0]] & !wb_hit1) |
                                  (b_use2_q & busy_q[b_rs2_q[AW-1:0]] & !wb_hit2));
`else
  logic unused_use;
  assign unused_use = b_use1_q | b_use2_q;
  assign raw_stall  = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_operand_fetch.sv
// tb_cpu_operand_fetch: directed vectors for the operand-fetch stage against a small register-file model.
module tb_cpu_operand_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  cpu_operand_fetch_if bus();
  cpu_operand_fetch #(.p_half_regfile(1'b0)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  logic [31:0] rf [32];
  function automatic logic [31:0] init_val(input int i);
    return (i == 0 || i == 3) ? 32'd0 : 32'h1000_0000 + i;
  endfunction
  // Synchronous 2R/1W register file: reads return the old value on a same-cycle write.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
      bus.i_rf_rd1_data <= '0;
      bus.i_rf_rd2_data <= '0;
    end else begin
      bus.i_rf_rd1_data <= rf[bus.o_rf_rd1_addr];
      bus.i_rf_rd2_data <= rf[bus.o_rf_rd2_addr];
      if (bus.i_wb_en && bus.i_wb_addr != 5'd0) rf[bus.i_wb_addr] <= bus.i_wb_data;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic u1, input logic u2, input logic we, input logic [31:0] tag);
    bus.i_dec_valid   = 1'b1;
    bus.i_dec_rs1     = rs1;
    bus.i_dec_rs2     = rs2;
    bus.i_dec_rd      = rd;
    bus.i_dec_use_rs1 = u1;
    bus.i_dec_use_rs2 = u2;
    bus.i_dec_rd_we   = we;
    bus.i_dec_tag     = tag;
  endtask
  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.i_wb_en   = 1'b1;
    bus.i_wb_addr = a;
    bus.i_wb_data = d;
  endtask
  initial begin
    bus.i_flush = 1'b0;
    bus.i_ex_ready = 1'b1;
    bus.i_wb_en = 1'b0;
    bus.i_wb_addr = '0;
    bus.i_wb_data = '0;
    dec(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    bus.i_dec_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", bus.o_ex_valid, 32'd0);
    chk("rst_stall", bus.o_stall_raw, 32'd0);
    chk("rst_dec_ready", bus.o_dec_ready, 32'd1);
    chk("rst_rs1", bus.o_ex_rs1_data, 32'd0);
    chk("rst_tag", bus.o_ex_tag, 32'd0);
    chk("rst_addr1", bus.o_rf_rd1_addr, 32'd0);
    rst = 1'b0;
    step();
    for (int k = 1; k <= 6; k++) begin
      if (k <= 5) dec(5'(k), 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h100 + k);
      else bus.i_dec_valid = 1'b0;
      #1;
      chk("b2b_valid", bus.o_ex_valid, 32'(k > 1));
      if (k <= 5) chk("b2b_addr", bus.o_rf_rd1_addr, k);
      if (k > 1) begin
        chk("b2b_rs1", bus.o_ex_rs1_data, init_val(k - 1));
        chk("b2b_tag", bus.o_ex_tag, 32'h100 + k - 1);
      end
      step();
    end
    dec(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h300);
    wb(5'd3, 32'hDEADBEEF);
    #1;
    chk("byp_empty", bus.o_ex_valid, 32'd0);
    step();
    bus.i_dec_valid = 1'b0;
    bus.i_wb_en = 1'b0;
    #1;
    chk("byp_valid", bus.o_ex_valid, 32'd1);
    chk("byp_rs1", bus.o_ex_rs1_data, 32'hDEADBEEF);
    step();
    dec(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 32'h700);
    #1;
    step();
    dec(5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 32'h701);
    #1;
    chk("lu_prod_valid", bus.o_ex_valid, 32'd1);
    chk("lu_prod_rd", bus.o_ex_rd, 32'd7);
    step();
    bus.i_dec_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) wb(5'd7, 32'h12345678);
      #1;
`ifdef CPU_OPFETCH_SCOREBOARD_EN
      chk("lu_stall", bus.o_stall_raw, 32'(c < 4));
      chk("lu_valid", bus.o_ex_valid, 32'(c == 4));
      if (c == 4) chk("lu_rs2", bus.o_ex_rs2_data, 32'h12345678);
`else
      chk("lu_stall", bus.o_stall_raw, 32'd0);
      chk("lu_valid", bus.o_ex_valid, 32'(c == 1));
      if (c == 1) chk("lu_rs2", bus.o_ex_rs2_data, 32'h10000007);
`endif
      step();
    end
    bus.i_wb_en = 1'b0;
    dec(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h900);
    #1;
    step();
    bus.i_ex_ready = 1'b0;
    dec(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h9FF);
    for (int q = 1; q <= 4; q++) begin
      if (q == 2) wb(5'd9, 32'hA5A5A5A5);
      else bus.i_wb_en = 1'b0;
      #1;
      chk("bp_dec_ready", bus.o_dec_ready, 32'd0);
      chk("bp_tag", bus.o_ex_tag, 32'h900);
      chk("bp_valid", bus.o_ex_valid, 32'd1);
      chk("bp_rs1", bus.o_ex_rs1_data, (q == 1) ? 32'h10000009 : 32'hA5A5A5A5);
      step();
    end
    bus.i_wb_en = 1'b0;
    bus.i_dec_valid = 1'b0;
    bus.i_ex_ready = 1'b1;
    #1;
    chk("bp_release_tag", bus.o_ex_tag, 32'h900);
    step();
    dec(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 32'hA00);
    wb(5'd0, 32'hFFFFFFFF);
    #1;
    step();
    dec(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hA01);
    #1;
    chk("x0_valid", bus.o_ex_valid, 32'd1);
    chk("x0_stall", bus.o_stall_raw, 32'd0);
    chk("x0_rs1", bus.o_ex_rs1_data, 32'd0);
    step();
    bus.i_dec_valid = 1'b0;
    bus.i_wb_en = 1'b0;
    #1;
    chk("x0_valid2", bus.o_ex_valid, 32'd1);
    chk("x0_stall2", bus.o_stall_raw, 32'd0);
    chk("x0_tag2", bus.o_ex_tag, 32'hA01);
    step();
    dec(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 32'hB00);
    #1;
    step();
    dec(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hB01);
    #1;
    chk("fl_prod_valid", bus.o_ex_valid, 32'd1);
    step();
    bus.i_dec_valid = 1'b0;
    bus.i_ex_ready = 1'b0;
    bus.i_flush = 1'b1;
    #1;
    chk("fl_dec_ready", bus.o_dec_ready, 32'd0);
`ifdef CPU_OPFETCH_SCOREBOARD_EN
    chk("fl_stall_before", bus.o_stall_raw, 32'd1);
`endif
    step();
    bus.i_flush = 1'b0;
    bus.i_ex_ready = 1'b1;
    dec(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hB02);
    #1;
    chk("fl_killed", bus.o_ex_valid, 32'd0);
    chk("fl_ready_after", bus.o_dec_ready, 32'd1);
    step();
    bus.i_dec_valid = 1'b0;
    #1;
    chk("fl_cons_valid", bus.o_ex_valid, 32'd1);
    chk("fl_cons_stall", bus.o_stall_raw, 32'd0);
    chk("fl_cons_tag", bus.o_ex_tag, 32'hB02);
    step();
    dec(5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 32'hC00);
    #1;
    step();
    bus.i_dec_valid = 1'b0;
    bus.i_ex_ready = 1'b0;
    #1;
    chk("ar_held", bus.o_ex_valid, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", bus.o_ex_valid, 32'd0);
    chk("ar_stall", bus.o_stall_raw, 32'd0);
    chk("ar_tag", bus.o_ex_tag, 32'd0);
    chk("ar_rd", bus.o_ex_rd, 32'd0);
    chk("ar_rd_we", bus.o_ex_rd_we, 32'd0);
    chk("ar_rs1", bus.o_ex_rs1_data, 32'd0);
    chk("ar_addr1", bus.o_rf_rd1_addr, 32'd0);
    chk("ar_dec_ready", bus.o_dec_ready, 32'd1);
    step();
    rst = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
